lc3_mem_responder: RTL and testbench

LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

---
 rtl/lc3_mem_pkg.sv | 27 ++
 rtl/lc3_mem_port_fsm.sv | 66 ++++++
 rtl/lc3_mem_responder.sv | 108 ++++++++++
 tb/tb_lc3_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
// The LC3_MEM_ERR_EN build option uses addr_oor() to flag out-of-range accesses.
package lc3_mem_pkg;

  localparam int unsigned LC3_WORD_W = 16;
  localparam int unsigned LC3_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lc3_port_state_e;

  // Request captured by the data port at acceptance
  typedef struct packed {
    logic                  rd;
    logic [LC3_WORD_W-1:0] din;
    logic [LC3_WORD_W-1:0] addr;
  } lc3_data_req_t;

  // True when any address bit at or above depth_log2 is set
  function automatic logic addr_oor(input logic [LC3_WORD_W-1:0] addr,
                                    input int unsigned depth_log2);
    return (32'(addr) >> depth_log2) != 32'd0;
  endfunction

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// Per-port IDLE/WAIT/DONE sequencer: captures a request payload and raises
// fire_c on the edge that enters DONE, so the top can access the array then.
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
#(
  parameter int unsigned LAT       = 1,
  parameter int unsigned PAYLOAD_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req,
  input  logic [PAYLOAD_W-1:0] payload,
  output logic                 fire_c,
  output logic [PAYLOAD_W-1:0] payload_c,
  output logic                 done
);

  localparam logic [LC3_CNT_W-1:0] WAIT_INIT = (LAT > 1) ? LC3_CNT_W'(LAT - 2) : '0;
  localparam logic                 SINGLE    = (LAT == 1);

  lc3_port_state_e      state;
  logic [LC3_CNT_W-1:0] cnt;
  logic [PAYLOAD_W-1:0] held;

  // With LAT = 1 the access happens on the accepting edge, so the live payload is used
  assign fire_c    = ((state == IDLE) && req && SINGLE) ||
                     ((state == WAIT) && (cnt == '0));
  assign payload_c = (state == IDLE) ? payload : held;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      held  <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            held <= payload;
            cnt  <= WAIT_INIT;
            done <= SINGLE;
            state <= SINGLE ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - LC3_CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Unified instruction/data word memory with independent fixed-latency ports.
// Define LC3_MEM_ERR_EN to add the mem_err port and out-of-range suppression.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int unsigned INSTR_LAT  = 1,
  parameter int unsigned DATA_LAT   = 2,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LC3_WORD_W-1:0] pc,
  input  logic                  instrmem_rd,
  output logic [LC3_WORD_W-1:0] Instr_dout,
  output logic                  complete_instr,
  input  logic [LC3_WORD_W-1:0] Data_addr,
  input  logic [LC3_WORD_W-1:0] Data_din,
  input  logic                  Data_rd,
  input  logic                  Data_req,
  output logic [LC3_WORD_W-1:0] Data_dout,
  output logic                  complete_data
`ifdef LC3_MEM_ERR_EN
  ,
  output logic                  mem_err
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [LC3_WORD_W-1:0] mem [DEPTH];

  logic                  i_fire;
  logic [LC3_WORD_W-1:0] i_addr;
  logic                  d_fire;
  lc3_data_req_t         d_req;
  lc3_data_req_t         d_cur;
  logic [DEPTH_LOG2-1:0] i_idx;
  logic [DEPTH_LOG2-1:0] d_idx;
  logic                  i_oor;
  logic                  d_oor;

  assign d_req = '{rd: Data_rd, din: Data_din, addr: Data_addr};

  lc3_mem_port_fsm #(
    .LAT       (INSTR_LAT),
    .PAYLOAD_W (LC3_WORD_W)
  ) u_instr_port (
    .clock     (clock),
    .reset     (reset),
    .req       (instrmem_rd),
    .payload   (pc),
    .fire_c    (i_fire),
    .payload_c (i_addr),
    .done      (complete_instr)
  );

  lc3_mem_port_fsm #(
    .LAT       (DATA_LAT),
    .PAYLOAD_W ($bits(lc3_data_req_t))
  ) u_data_port (
    .clock     (clock),
    .reset     (reset),
    .req       (Data_req),
    .payload   (d_req),
    .fire_c    (d_fire),
    .payload_c (d_cur),
    .done      (complete_data)
  );

  assign i_idx = i_addr[DEPTH_LOG2-1:0];
  assign d_idx = d_cur.addr[DEPTH_LOG2-1:0];

`ifdef LC3_MEM_ERR_EN
  assign i_oor = addr_oor(i_addr, DEPTH_LOG2);
  assign d_oor = addr_oor(d_cur.addr, DEPTH_LOG2);
`else
  // Upper address bits simply alias onto the low index
  logic unused_addr_hi;
  assign unused_addr_hi = ^{i_addr, d_cur.addr};
  assign i_oor = 1'b0;
  assign d_oor = 1'b0;
`endif

  // Array access happens on the edge entering DONE; the array itself is never reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Instr_dout <= '0;
      Data_dout  <= '0;
`ifdef LC3_MEM_ERR_EN
      mem_err    <= 1'b0;
`endif
    end else begin
      if (i_fire) begin
        Instr_dout <= i_oor ? '0 : mem[i_idx];
      end
      if (d_fire && d_cur.rd) begin
        Data_dout <= d_oor ? '0 : mem[d_idx];
      end
      if (d_fire && !d_cur.rd && !d_oor) begin
        mem[d_idx] <= d_cur.din;
      end
`ifdef LC3_MEM_ERR_EN
      mem_err <= (i_fire && i_oor) || (d_fire && d_oor);
`endif
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: directed scenarios plus random
// traffic checked against a word-array reference model.
module tb_lc3_mem_responder;

  localparam int unsigned ILAT  = 1;
  localparam int unsigned DLAT  = 2;
  localparam int unsigned DL2   = 8;
  localparam int unsigned DEPTH = 1 << DL2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc = '0;
  logic        instrmem_rd = 1'b0;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic [15:0] Data_addr = '0;
  logic [15:0] Data_din = '0;
  logic        Data_rd = 1'b0;
  logic        Data_req = 1'b0;
  logic [15:0] Data_dout;
  logic        complete_data;
`ifdef LC3_MEM_ERR_EN
  logic        mem_err;
  logic        mem_err3;
`endif

  logic        rd3 = 1'b0;
  logic [15:0] instr_dout3;
  logic        complete_instr3;
  logic [15:0] data_dout3;
  logic        complete_data3;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] mm [DEPTH];
  logic [15:0] exp_i = '0;
  logic [15:0] exp_d = '0;

  always #5 clock = ~clock;

  lc3_mem_responder #(.INSTR_LAT(ILAT), .DATA_LAT(DLAT), .DEPTH_LOG2(DL2)) u_dut (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd), .Data_req(Data_req),
    .Data_dout(Data_dout), .complete_data(complete_data)
`ifdef LC3_MEM_ERR_EN
    , .mem_err(mem_err)
`endif
  );

  lc3_mem_responder #(.INSTR_LAT(3), .DATA_LAT(DLAT), .DEPTH_LOG2(DL2)) u_dut3 (
    .clock(clock), .reset(reset), .pc(16'h0010), .instrmem_rd(rd3),
    .Instr_dout(instr_dout3), .complete_instr(complete_instr3),
    .Data_addr(16'h0000), .Data_din(16'h0000), .Data_rd(1'b0), .Data_req(1'b0),
    .Data_dout(data_dout3), .complete_data(complete_data3)
`ifdef LC3_MEM_ERR_EN
    , .mem_err(mem_err3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit oor(input logic [15:0] a);
`ifdef LC3_MEM_ERR_EN
    return (32'(a) >> DL2) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int idx(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  // One transaction: data request at cycle 0, instruction request at cycle ioff
  task automatic run(input bit do_i, input logic [15:0] a_i, input int ioff,
                     input bit do_d, input bit rd, input logic [15:0] a_d,
                     input logic [15:0] din, input string tag);
    int ci_cyc = -1, cd_cyc = -1, ci_n = 0, cd_n = 0, me_bad = 0;
    logic [15:0] got_i = '0, got_d = '0;
    int ei = ioff + int'(ILAT);
    int ed = int'(DLAT);
    bit oi = oor(a_i);
    bit od = oor(a_d);
    if (do_i) begin
      if (oi) exp_i = '0;
      else if (do_d && !rd && !od && idx(a_d) == idx(a_i) && ed < ei) exp_i = din;
      else exp_i = mm[idx(a_i)];
    end
    if (do_d) begin
      if (rd) exp_d = od ? 16'h0000 : mm[idx(a_d)];
      else if (!od) mm[idx(a_d)] = din;
    end
    for (int c = 0; c < 10; c++) begin
      Data_req    = do_d && (c == 0);
      Data_addr   = (c == 0) ? a_d : 16'($urandom);
      Data_din    = (c == 0) ? din : 16'($urandom);
      Data_rd     = (c == 0) ? rd : 1'($urandom);
      instrmem_rd = do_i && (c == ioff);
      pc          = (c == ioff) ? a_i : 16'($urandom);
      @(posedge clock); #1;
      if (complete_instr) begin
        ci_n++;
        if (ci_cyc < 0) begin ci_cyc = c + 1; got_i = Instr_dout; end
      end
      if (complete_data) begin
        cd_n++;
        if (cd_cyc < 0) begin cd_cyc = c + 1; got_d = Data_dout; end
      end
`ifdef LC3_MEM_ERR_EN
      if (mem_err !== ((complete_instr && oi) || (complete_data && od))) me_bad++;
`endif
    end
    Data_req = 1'b0;
    instrmem_rd = 1'b0;
    chk({tag, "/i_pulses"}, 32'(ci_n), do_i ? 32'd1 : 32'd0);
    chk({tag, "/d_pulses"}, 32'(cd_n), do_d ? 32'd1 : 32'd0);
    if (do_i) begin
      chk({tag, "/i_lat"}, 32'(ci_cyc), 32'(ei));
      chk({tag, "/i_data"}, 32'(got_i), 32'(exp_i));
    end
    if (do_d) chk({tag, "/d_lat"}, 32'(cd_cyc), 32'(ed));
    if (do_d && rd) chk({tag, "/d_data"}, 32'(got_d), 32'(exp_d));
    chk({tag, "/i_hold"}, 32'(Instr_dout), 32'(exp_i));
    chk({tag, "/d_hold"}, 32'(Data_dout), 32'(exp_d));
`ifdef LC3_MEM_ERR_EN
    chk({tag, "/mem_err"}, 32'(me_bad), 32'd0);
`endif
  endtask

  // Hold the instruction strobe high for 6 cycles and compare pulse cycles
  task automatic hold_run(input bit on3, input int lat, input string tag);
    int exp_q[$];
    int got_q[$];
    int t = 0;
    while (t < 6) begin
      exp_q.push_back(t + lat);
      t += lat + 1;
    end
    if (!on3) pc = 16'h0010;
    for (int c = 0; c < 14; c++) begin
      if (on3) rd3 = (c < 6); else instrmem_rd = (c < 6);
      @(posedge clock); #1;
      if (on3 ? complete_instr3 : complete_instr) got_q.push_back(c + 1);
    end
    rd3 = 1'b0;
    instrmem_rd = 1'b0;
    chk({tag, "/count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk({tag, "/cycle"}, 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  initial begin
    int saw;
    repeat (3) @(posedge clock);
    #1;
    chk("rst/complete_instr", 32'(complete_instr), 32'd0);
    chk("rst/complete_data", 32'(complete_data), 32'd0);
    chk("rst/Instr_dout", 32'(Instr_dout), 32'd0);
    chk("rst/Data_dout", 32'(Data_dout), 32'd0);
    reset = 1'b1;

    // Give every word a known value
    for (int i = 0; i < int'(DEPTH); i++)
      run(1'b0, 16'h0, 0, 1'b1, 1'b0, 16'(i), 16'($urandom), "fill");
    run(1'b0, 16'h0, 0, 1'b1, 1'b0, 16'h0005, 16'h0000, "clr5");

    run(1'b0, 16'h0, 0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, "beef_wr");
    run(1'b1, 16'h0010, 0, 1'b0, 1'b0, 16'h0, 16'h0, "beef_rd");
    chk("beef_value", 32'(exp_i), 32'h0000BEEF);

    hold_run(1'b0, int'(ILAT), "hold_lat1");
    hold_run(1'b1, 3, "hold_lat3");

    // Same-edge completion: instruction read sees the pre-write word
    run(1'b1, 16'h0005, 1, 1'b1, 1'b0, 16'h0005, 16'h1234, "same_edge");
    chk("same_edge_old", 32'(exp_i), 32'h00000000);
    run(1'b1, 16'h0005, 0, 1'b0, 1'b0, 16'h0, 16'h0, "after_write");
    chk("after_write_new", 32'(exp_i), 32'h00001234);

    // Reset during WAIT of a write aborts it
    Data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h0033; Data_din = 16'hAAAA;
    @(posedge clock); #1;
    Data_req = 1'b0;
    chk("abort/in_wait_no_pulse", 32'(complete_data), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("abort/complete_instr", 32'(complete_instr), 32'd0);
    chk("abort/complete_data", 32'(complete_data), 32'd0);
    chk("abort/Instr_dout", 32'(Instr_dout), 32'd0);
    chk("abort/Data_dout", 32'(Data_dout), 32'd0);
    saw = 0;
    repeat (2) begin
      @(posedge clock); #1;
      if (complete_data) saw++;
    end
    reset = 1'b1;
    exp_i = '0;
    exp_d = '0;
    repeat (4) begin
      @(posedge clock); #1;
      if (complete_data) saw++;
    end
    chk("abort/no_complete_data", 32'(saw), 32'd0);
    run(1'b0, 16'h0, 0, 1'b1, 1'b1, 16'h0033, 16'h0, "abort_readback");
    chk("abort/old_value", 32'(exp_d == 16'hAAAA && mm[8'h33] != 16'hAAAA), 32'd0);

    // Address above the array: aliases to index 0, or flags an error when enabled
    run(1'b0, 16'h0, 0, 1'b1, 1'b1, 16'h0100, 16'h0, "high_addr");
`ifdef LC3_MEM_ERR_EN
    chk("high_addr_zero", 32'(exp_d), 32'd0);
`else
    chk("high_addr_alias", 32'(exp_d), 32'(mm[0]));
`endif

    for (int n = 0; n < 80; n++) begin
      logic [15:0] ai, ad;
      ai = 16'($urandom);
      ad = ($urandom_range(0, 3) == 0) ? ai : 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        ai = ai & 16'h00FF;
        ad = ad & 16'h00FF;
      end
      run(1'($urandom), ai, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom),
          ad, 16'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
